// File: rtl/rom_port_arbiter_pkg.sv
// Shared widths and encodings for the ROM read-port arbiter.
package rom_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  // Owner of the single in-flight ROM read.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  // Round-robin priority: which input wins the next contended cycle.
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

endpackage

// File: rtl/rom_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; one-hot combinational grants, registered priority.
module rr_arb2
  import rom_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  prio_e prio_q;

  // Grant the sole requester, or the prioritised one under contention.
  always_comb begin
    gnt_a = req_a & (~req_b | (prio_q == PRIO_A));
    gnt_b = req_b & ~gnt_a;
  end

  // Winner drops to lowest priority; priority holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= PRIO_A;
    end else if (gnt_a) begin
      prio_q <= PRIO_B;
    end else if (gnt_b) begin
      prio_q <= PRIO_A;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the instruction ROM read port between fetch (IF) and load/store (LS).
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  if_flush_i,
  input  logic                  ls_req_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  rom_ce_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i
);

  owner_e owner_q;
  logic   if_elig;
  logic   ls_elig;

  // Reset masks eligibility so grants and ROM drive stay idle during reset.
  always_comb begin
    if_elig = if_req_i & ~if_flush_i & ~rst_i;
    ls_elig = ls_req_i & ~rst_i;
  end

  rr_arb2 u_arb (
    .clk   (clk_i),
    .rst   (rst_i),
    .req_a (if_elig),
    .req_b (ls_elig),
    .gnt_a (if_gnt_o),
    .gnt_b (ls_gnt_o)
  );

  // ROM chip-enable and address follow the granted requester.
  always_comb begin
    rom_ce_o   = if_gnt_o | ls_gnt_o;
    rom_addr_o = '0;
    if (if_gnt_o) begin
      rom_addr_o = if_addr_i;
    end else if (ls_gnt_o) begin
      rom_addr_o = ls_addr_i;
    end
  end

  // Remember who owns the read whose data returns next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWN_NONE;
    end else if (if_gnt_o) begin
      owner_q <= OWN_IF;
    end else if (ls_gnt_o) begin
      owner_q <= OWN_LS;
    end else begin
      owner_q <= OWN_NONE;
    end
  end

  // Route returning data; flush drops fetch data, reset drops everything.
  always_comb begin
    if_rvalid_o = (owner_q == OWN_IF) & ~if_flush_i & ~rst_i;
    ls_rvalid_o = (owner_q == OWN_LS) & ~rst_i;
    if_rdata_o  = if_rvalid_o ? rom_data_i : '0;
    ls_rdata_o  = ls_rvalid_o ? rom_data_i : '0;
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomised and directed bench for rom_port_arbiter against a behavioural model.
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_flush_i = 1'b0;
  logic        ls_req_i = 1'b0;
  logic [31:0] ls_addr_i = '0;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i = '0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  rom_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .if_flush_i  (if_flush_i),
    .ls_req_i    (ls_req_i),
    .ls_addr_i   (ls_addr_i),
    .ls_gnt_o    (ls_gnt_o),
    .ls_rvalid_o (ls_rvalid_o),
    .ls_rdata_o  (ls_rdata_o),
    .rom_ce_o    (rom_ce_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i)
  );

  // ROM contents are a fixed scramble of the address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
  endfunction

  // Registered ROM: data for an enabled address appears next cycle.
  always @(posedge clk) if (rom_ce_o) rom_data_i <= rom_word(rom_addr_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Model state: whose turn under contention, and the read issued last cycle.
  bit          if_turn = 1'b1;
  int          pend_who = 0;      // 0 none, 1 fetch, 2 load
  logic [31:0] pend_addr = '0;
  bit          last_ig, last_lg;

  task automatic step(input bit r, input bit ir, input logic [31:0] ia, input bit fl,
                      input bit lr, input logic [31:0] la);
    bit          if_ok, ls_ok, e_ig, e_lg, e_irv, e_lrv;
    logic [31:0] e_addr;
    @(negedge clk);
    rst_i = r; if_req_i = ir; if_addr_i = ia; if_flush_i = fl; ls_req_i = lr; ls_addr_i = la;
    #1;
    if_ok  = !r && ir && !fl;
    ls_ok  = !r && lr;
    e_ig   = if_ok && (!ls_ok || if_turn);
    e_lg   = ls_ok && !e_ig;
    e_addr = e_ig ? ia : (e_lg ? la : 32'h0);
    e_irv  = !r && pend_who == 1 && !fl;
    e_lrv  = !r && pend_who == 2;
    check("if_gnt",    {31'b0, if_gnt_o},    {31'b0, e_ig});
    check("ls_gnt",    {31'b0, ls_gnt_o},    {31'b0, e_lg});
    check("rom_ce",    {31'b0, rom_ce_o},    {31'b0, e_ig || e_lg});
    check("rom_addr",  rom_addr_o,           e_addr);
    check("if_rvalid", {31'b0, if_rvalid_o}, {31'b0, e_irv});
    check("ls_rvalid", {31'b0, ls_rvalid_o}, {31'b0, e_lrv});
    check("if_rdata",  if_rdata_o,           e_irv ? rom_word(pend_addr) : 32'h0);
    check("ls_rdata",  ls_rdata_o,           e_lrv ? rom_word(pend_addr) : 32'h0);
    last_ig = e_ig;
    last_lg = e_lg;
    @(posedge clk);
    if (r) begin
      if_turn  = 1'b1;
      pend_who = 0;
    end else if (e_ig) begin
      if_turn = 1'b0; pend_who = 1; pend_addr = ia;
    end else if (e_lg) begin
      if_turn = 1'b1; pend_who = 2; pend_addr = la;
    end else begin
      pend_who = 0;
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit          ir, lr, fl, r;
    logic [31:0] ia, la;

    // Reset values.
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h40, 0, 1, 32'h80);

    // Single fetch from 0x10.
    step(0, 1, 32'h10, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Continuous contention from a fresh reset: IF, LS, IF, LS ...
    step(1, 0, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 6; i++) step(0, 1, 32'h0, 0, 1, 32'h100);
    idle(1);

    // Fetch issued, then flush in the response cycle with LS waiting.
    step(0, 1, 32'h20, 0, 0, 0);
    step(0, 1, 32'h24, 1, 1, 32'h104);
    idle(1);

    // Reset right after an LS grant, then contention goes to IF first.
    step(0, 0, 0, 0, 1, 32'h108);
    step(1, 1, 32'h30, 0, 1, 32'h10C);
    step(1, 1, 32'h30, 0, 1, 32'h10C);
    step(0, 1, 32'h30, 0, 1, 32'h10C);
    step(0, 0, 0, 0, 1, 32'h10C);
    idle(5);

    // Back-to-back loads.
    step(0, 0, 0, 0, 1, 32'h100);
    step(0, 0, 0, 0, 1, 32'h104);
    step(0, 0, 0, 0, 1, 32'h108);
    idle(2);

    // Random traffic; requests and addresses are held until granted.
    ir = 0; lr = 0; ia = '0; la = '0;
    for (int unsigned i = 0; i < 3000; i++) begin
      if (!(ir && !last_ig)) begin
        ir = ($urandom % 4) != 0;
        ia = {$urandom_range(0, 16'hFFFF), 2'b00};
      end
      if (!(lr && !last_lg)) begin
        lr = ($urandom % 3) != 0;
        la = {$urandom_range(0, 16'hFFFF), 2'b00};
      end
      fl = ($urandom % 5) == 0;
      r  = ($urandom % 40) == 0;
      step(r, ir, ia, fl, lr, la);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
